// File: rtl/trdb_packet_unpacker.sv
// Trace packet unpacker: reassembles the LSB-first 32-bit word stream from the
// trace packet emitter into full-width packets (length field plus payload).
// Words go into an assembly register. When a packet completes, it moves into a
// separate output register with its padding bits cleared.
module trdb_packet_unpacker #(
  parameter int PACKET_LEN = 128,
  parameter int WORD_W     = 32,
  parameter int LEN_W      = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WORD_W-1:0]     word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic [PACKET_LEN-1:0] packet_o,
  output logic                  packet_valid_o,
  input  logic                  packet_ready_i,
  output logic                  err_o,
  output logic [15:0]           pkt_cnt_o
);

  localparam int NWORDS = PACKET_LEN / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS + 1);
  localparam int TW     = $clog2(PACKET_LEN + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state;
  logic [IDX_W-1:0]      rem;
  logic [IDX_W-1:0]      idx;
  logic [TW-1:0]         total_bits;
  logic [PACKET_LEN-1:0] asm_reg;
  logic [PACKET_LEN-1:0] out_reg;
  logic                  out_valid;
  logic                  err_reg;
  logic [15:0]           pkt_cnt;

  int                    hdr_total;
  int                    hdr_words;
  int                    cur_total;
  logic                  oversize;
  logic                  completing;
  logic                  word_xfer;
  logic                  pkt_xfer;
  logic [IDX_W-1:0]      write_idx;
  logic [PACKET_LEN-1:0] merged;
  logic [PACKET_LEN-1:0] masked;

  // Decode the header in word_i, merge the incoming word into the assembly image and clear bits beyond the packet length
  always_comb begin
    hdr_total = int'(word_i[LEN_W-1:0]) + LEN_W;
    hdr_words = (hdr_total + WORD_W - 1) / WORD_W;
    oversize  = hdr_total > PACKET_LEN;
    cur_total = (state == IDLE) ? hdr_total : int'(total_bits);
    if (state == IDLE) begin
      completing = !oversize && (hdr_total <= WORD_W);
      write_idx  = '0;
      merged     = '0;
    end else begin
      completing = (rem == IDX_W'(1));
      write_idx  = idx;
      merged     = asm_reg;
    end
    for (int w = 0; w < NWORDS; w++) begin
      if (IDX_W'(w) == write_idx) begin
        merged[w*WORD_W +: WORD_W] = word_i;
      end
    end
    for (int i = 0; i < PACKET_LEN; i++) begin
      masked[i] = (i < cur_total) ? merged[i] : 1'b0;
    end
  end

  // Refuse only a completing word while the output register is held; everything else flows
  always_comb begin
    word_ready_o = !rst_i && (!completing || !out_valid || packet_ready_i);
    word_xfer    = word_valid_i && word_ready_o;
    pkt_xfer     = out_valid && packet_ready_i;
  end

  // Collection FSM, output register, error pulse and delivered-packet counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rem        <= '0;
      idx        <= '0;
      total_bits <= '0;
      asm_reg    <= '0;
      out_reg    <= '0;
      out_valid  <= 1'b0;
      err_reg    <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      err_reg <= 1'b0;
      if (pkt_xfer) begin
        out_valid <= 1'b0;
        pkt_cnt   <= pkt_cnt + 16'd1;
      end
      if (word_xfer) begin
        case (state)
          IDLE: begin
            if (oversize) begin
              err_reg <= 1'b1;
            end else if (completing) begin
              out_reg   <= masked;
              out_valid <= 1'b1;
            end else begin
              asm_reg    <= merged;
              rem        <= IDX_W'(hdr_words - 1);
              idx        <= IDX_W'(1);
              total_bits <= TW'(hdr_total);
              state      <= COLLECT;
            end
          end
          COLLECT: begin
            asm_reg <= merged;
            if (completing) begin
              out_reg   <= masked;
              out_valid <= 1'b1;
              rem       <= '0;
              idx       <= '0;
              state     <= IDLE;
            end else begin
              rem <= rem - IDX_W'(1);
              idx <= idx + IDX_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign packet_o       = out_reg;
  assign packet_valid_o = out_valid;
  assign err_o          = err_reg;
  assign pkt_cnt_o      = pkt_cnt;

endmodule

// File: tb/tb_trdb_packet_unpacker.sv
// Bench for trdb_packet_unpacker. Expected packets go into a queue when they
// are offered. A negedge monitor pops and compares every delivered packet.
module tb_trdb_packet_unpacker;

  localparam int NRAND = 40;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  word_i;
  logic         word_valid_i;
  logic         word_ready_o;
  logic [127:0] packet_o;
  logic         packet_valid_o;
  logic         packet_ready_i;
  logic         err_o;
  logic [15:0]  pkt_cnt_o;

  logic         ready_ctl;
  logic         rand_mode;
  logic [127:0] exp_q[$];
  logic [15:0]  exp_cnt;
  int           checks;
  int           errors;

  trdb_packet_unpacker dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .word_i         (word_i),
    .word_valid_i   (word_valid_i),
    .word_ready_o   (word_ready_o),
    .packet_o       (packet_o),
    .packet_valid_o (packet_valid_o),
    .packet_ready_i (packet_ready_i),
    .err_o          (err_o),
    .pkt_cnt_o      (pkt_cnt_o)
  );

  // 10 ns clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Downstream ready: directed value, or random during the stream phase
  always @(posedge clk_i) begin
    #2;
    packet_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivered packet must match the head of the scoreboard
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_cnt = 16'd0;
    end else if (packet_valid_o && packet_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_packet: got %h expected none", packet_o);
      end else begin
        checkOutput("packet", packet_o, exp_q.pop_front());
        checkOutput("pkt_cnt", {112'd0, pkt_cnt_o}, {112'd0, exp_cnt});
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  // Offer one word (entered just after a posedge) and wait until it transfers
  task automatic applyStimulus(input logic [31:0] w);
    bit done;
    done = 0;
    word_i = w;
    word_valid_i = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_i);
      if (word_ready_o) done = 1;
      @(posedge clk_i);
      #1;
    end
    word_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL word_timeout: got stalled expected accepted for %h", w);
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk_i);
      #1;
      if (exp_q.size() == 0 && !packet_valid_o) done = 1;
    end
    @(posedge clk_i);
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  function automatic logic [127:0] modelPacket(input logic [127:0] raw, input int total);
    logic [127:0] r;
    r = raw;
    for (int i = 0; i < 128; i++) if (i >= total) r[i] = 1'b0;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 16'd0;
    rst_i = 1'b1;
    word_i = 32'd0;
    word_valid_i = 1'b0;
    ready_ctl = 1'b1;
    rand_mode = 1'b0;

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("ready_in_reset", {127'd0, word_ready_o}, 128'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_valid", {127'd0, packet_valid_o}, 128'd0);
    checkOutput("rst_packet", packet_o, 128'd0);
    checkOutput("rst_err", {127'd0, err_o}, 128'd0);
    checkOutput("rst_cnt", {112'd0, pkt_cnt_o}, 128'd0);
    checkOutput("rst_ready", {127'd0, word_ready_o}, 128'd1);
    @(posedge clk_i);
    #1;

    // Single-word packet, L=25
    exp_q.push_back(128'h0A19);
    applyStimulus(32'h0000_0A19);
    @(negedge clk_i);
    checkOutput("single_latency", {127'd0, packet_valid_o}, 128'd1);
    @(posedge clk_i);
    #1;
    waitDrain();

    // Four-word packet, L=100
    exp_q.push_back(128'h0000_07FF_2222_2222_1111_1111_DEAD_BE64);
    applyStimulus(32'hDEAD_BE64);
    applyStimulus(32'h1111_1111);
    applyStimulus(32'h2222_2222);
    applyStimulus(32'hFFFF_FFFF);
    @(negedge clk_i);
    checkOutput("multi_latency", {127'd0, packet_valid_o}, 128'd1);
    @(posedge clk_i);
    #1;
    waitDrain();

    // Malformed header L=127, then L=0 and L=5 headers
    applyStimulus(32'h0000_007F);
    @(negedge clk_i);
    checkOutput("err_pulse", {127'd0, err_o}, 128'd1);
    checkOutput("err_no_valid", {127'd0, packet_valid_o}, 128'd0);
    @(negedge clk_i);
    checkOutput("err_one_cycle", {127'd0, err_o}, 128'd0);
    @(posedge clk_i);
    #1;
    exp_q.push_back(128'h0);
    exp_q.push_back(128'h685);
    applyStimulus(32'hFFFF_FF80);
    applyStimulus(32'h1234_5685);
    waitDrain();

    // Backpressure: A held in out, B refused until downstream frees it
    ready_ctl = 1'b0;
    exp_q.push_back(128'h00FE_0011);
    exp_q.push_back(128'h55AA_5518);
    applyStimulus(32'hCAFE_0011);
    word_i = 32'h55AA_5518;
    word_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checkOutput("bp_ready_low", {127'd0, word_ready_o}, 128'd0);
      checkOutput("bp_hold", packet_o, 128'h00FE_0011);
    end
    @(posedge clk_i);
    #1;
    ready_ctl = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_release", {127'd0, word_ready_o}, 128'd1);
    @(posedge clk_i);
    #1;
    word_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("bp_next_valid", {127'd0, packet_valid_o}, 128'd1);
    @(posedge clk_i);
    #1;
    waitDrain();
    checkOutput("cnt_before_reset", {112'd0, pkt_cnt_o}, 128'd6);

    // Reset after two words of a four-word packet
    applyStimulus(32'h0000_0064);
    applyStimulus(32'h1111_1111);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("mid_rst_ready", {127'd0, word_ready_o}, 128'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("mid_rst_valid", {127'd0, packet_valid_o}, 128'd0);
    checkOutput("mid_rst_cnt", {112'd0, pkt_cnt_o}, 128'd0);
    @(posedge clk_i);
    #1;
    exp_q.push_back(128'h0A19);
    applyStimulus(32'h0000_0A19);
    waitDrain();

    // Random-length stream with random gaps and downstream stalls
    rand_mode = 1'b1;
    for (int p = 0; p < NRAND; p++) begin
      logic [127:0] raw;
      int len;
      int total;
      int nw;
      len = $urandom_range(0, 121);
      total = len + 7;
      nw = (total + 31) / 32;
      for (int w = 0; w < 4; w++) raw[w*32 +: 32] = $urandom;
      raw[6:0] = 7'(len);
      exp_q.push_back(modelPacket(raw, total));
      for (int w = 0; w < nw; w++) begin
        applyStimulus(raw[w*32 +: 32]);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    rand_mode = 1'b0;
    ready_ctl = 1'b1;
    waitDrain();
    checkOutput("final_cnt", {112'd0, pkt_cnt_o}, 128'(NRAND + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
